// File: rtl/pi_sequencer_pkg.sv
// pi_sequencer_pkg: sequencer state encoding, pi_length-to-bit-count mapping and default timeout
package pi_sequencer_pkg;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPT, S_LOAD, S_WAIT_V, S_SHIFT, S_FIN} state_e;
  function automatic logic [5:0] bit_count(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction
endpackage

// File: rtl/pi_bitcnt.sv
// pi_bitcnt: so_valid fall detector plus saturating valid-cycle counter checked against pi_length
module pi_bitcnt import pi_sequencer_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       so_valid_i,
  input  logic [1:0] len_i,
  output logic       fall_o,
  output logic       mismatch_o
);
  logic       sv_q;
  logic [5:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? 6'd0 : (en_i && so_valid_i && cnt_q != 6'd63) ? cnt_q + 6'd1 : cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sv_q  <= 1'b0;
      cnt_q <= 6'd0;
    end else begin
      sv_q  <= so_valid_i;
      cnt_q <= cnt_d;
    end
  end
  assign fall_o     = sv_q & ~so_valid_i;
  assign mismatch_o = (cnt_q == 6'd63) || (cnt_q != bit_count(len_i));
endmodule

// File: rtl/pi_sequencer.sv
// pi_sequencer: walks pattern/stimulus word pairs, loads the serializer and checks each serialized length
module pi_sequencer import pi_sequencer_pkg::*; #(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_pat,
  input  logic [15:0]       mem_sti,
  output logic              load,
  output logic [15:0]       pi_data,
  output logic [1:0]        pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  input  logic              so_valid,
  output logic              busy,
  output logic              done,
  output logic              tmo_err,
  output logic              len_err
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, last_q, last_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        len_q, len_d;
  logic              fill_q, fill_d, msb_q, msb_d, low_q, low_d;
  logic              end_q, end_d, tmo_q, tmo_d, lerr_q, lerr_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic              fall, mismatch;

  pi_bitcnt u_bitcnt (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (state_q == S_LOAD),
    .en_i       (state_q == S_WAIT_V || state_q == S_SHIFT),
    .so_valid_i (so_valid),
    .len_i      (len_q),
    .fall_o     (fall),
    .mismatch_o (mismatch)
  );

  // wcnt_q holds the number of cycles elapsed since the load strobe
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    data_d  = data_q;
    len_d   = len_q;
    fill_d  = fill_q;
    msb_d   = msb_q;
    low_d   = low_q;
    end_d   = end_q;
    tmo_d   = tmo_q;
    lerr_d  = lerr_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        last_d  = last_addr;
        addr_d  = '0;
        tmo_d   = 1'b0;
        lerr_d  = 1'b0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_CAPT;
      S_CAPT: begin
        data_d  = mem_pat;
        len_d   = mem_sti[13:12];
        fill_d  = mem_sti[8];
        msb_d   = mem_sti[4];
        low_d   = mem_sti[0];
        end_d   = addr_q == last_q;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        wcnt_d  = WW'(1);
        state_d = S_WAIT_V;
      end
      S_WAIT_V: if (so_valid) state_d = S_SHIFT;
        else if (wcnt_q >= WW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_FIN;
        end else wcnt_d = wcnt_q + WW'(1);
      S_SHIFT: if (fall) begin
        lerr_d = lerr_q | mismatch;
        if (addr_q == last_q) state_d = S_FIN;
        else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_FIN: begin
        end_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      fill_q  <= 1'b0;
      msb_q   <= 1'b0;
      low_q   <= 1'b0;
      end_q   <= 1'b0;
      tmo_q   <= 1'b0;
      lerr_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      msb_q   <= msb_d;
      low_q   <= low_d;
      end_q   <= end_d;
      tmo_q   <= tmo_d;
      lerr_q  <= lerr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign mem_rd    = state_q == S_FETCH;
  assign mem_addr  = addr_q;
  assign load      = state_q == S_LOAD;
  assign pi_data   = data_q;
  assign pi_length = len_q;
  assign pi_fill   = fill_q;
  assign pi_msb    = msb_q;
  assign pi_low    = low_q;
  assign pi_end    = end_q;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_FIN;
  assign tmo_err   = tmo_q;
  assign len_err   = lerr_q;
endmodule

// File: tb/tb_pi_sequencer.sv
// tb_pi_sequencer: randomized runs against a word-level model of the sequencer plus a serializer model
module tb_pi_sequencer;
  localparam int AW  = 7;
  localparam int TMO = 16;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    len;
    logic          fill, msb, low, end_;
  } rec_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, so_valid = 1'b0;
  logic [AW-1:0] last_addr = '0, mem_addr;
  logic [15:0] mem_pat, mem_sti, pi_data;
  logic [1:0] pi_length;
  logic mem_rd, load, pi_fill, pi_msb, pi_low, pi_end, busy, done, tmo_err, len_err;
  logic [15:0] pat [128];
  logic [15:0] sti [128];
  int nval [128];
  int dly [128];
  rec_t got_q[$], exp_q[$];
  int done_cnt = 0, n_chk = 0, n_fail = 0;
  logic exp_len, exp_tmo;

  always #5 clk = ~clk;

  pi_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .last_addr(last_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_pat(mem_pat), .mem_sti(mem_sti),
    .load(load), .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
    .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end), .so_valid(so_valid),
    .busy(busy), .done(done), .tmo_err(tmo_err), .len_err(len_err)
  );

  always @(posedge clk) if (mem_rd) begin
    mem_pat <= pat[mem_addr];
    mem_sti <= sti[mem_addr];
  end

  always @(negedge clk) begin
    if (load) got_q.push_back(rec_t'{mem_addr, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end});
    if (done) done_cnt++;
  end

  // serializer: after dly[a] cycles, holds so_valid high for nval[a] cycles (0 = never responds)
  initial forever begin
    @(negedge clk);
    if (load) begin
      automatic int a = int'(mem_addr);
      repeat (dly[a]) @(negedge clk);
      so_valid = nval[a] > 0;
      repeat (nval[a]) @(negedge clk);
      so_valid = 1'b0;
    end
  end

  function automatic void model_run(input int last);
    exp_q.delete();
    exp_len = 1'b0;
    exp_tmo = 1'b0;
    for (int a = 0; a <= last; a++) begin
      exp_q.push_back(rec_t'{AW'(a), pat[a], sti[a][13:12], sti[a][8], sti[a][4], sti[a][0], a == last});
      if (nval[a] == 0) begin
        exp_tmo = 1'b1;
        break;
      end
      if (nval[a] != 8 * (int'(sti[a][13:12]) + 1)) exp_len = 1'b1;
    end
  endfunction

  task automatic fill_rand(input int last, input bit allow_bad);
    for (int a = 0; a <= last; a++) begin
      automatic int r = int'($urandom_range(0, 7));
      pat[a] = 16'($urandom);
      sti[a] = 16'($urandom);
      nval[a] = 8 * (int'(sti[a][13:12]) + 1);
      if (allow_bad && r == 0) nval[a] = 0;
      if (allow_bad && r == 1) nval[a] = int'($urandom_range(1, 40));
      dly[a] = int'($urandom_range(1, 6));
    end
  endtask

  task automatic kick(input int last);
    got_q.delete();
    done_cnt = 0;
    last_addr = AW'(last);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({mem_addr, pi_data, pi_length, pi_fill, pi_msb, pi_low, load, mem_rd, pi_end, busy, done, tmo_err, len_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h data=%h busy=%b done=%b, required all zero", mem_addr, pi_data, busy, done);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_single;
    int cyc;
    pat[0] = 16'h00A5; sti[0] = 16'h0000; nval[0] = 8; dly[0] = 2;
    kick(0);
    cyc = 1;
    while (!load && cyc < 10) begin @(negedge clk); cyc++; end
    n_chk++;
    if (cyc !== 3) begin n_fail++; $display("FAIL single_load_latency: got %0d exp 3", cyc); end
    n_chk++;
    if ({pi_data, pi_length, pi_end} !== {16'h00A5, 2'b00, 1'b1}) begin
      n_fail++; $display("FAIL single_pi: got data=%h len=%0d end=%b exp 00a5/0/1", pi_data, pi_length, pi_end);
    end
    wait_done(200);
    n_chk++;
    if ({done_cnt, tmo_err, len_err, busy} !== {32'd1, 3'b000}) begin
      n_fail++; $display("FAIL single_end: got done=%0d tmo=%b len=%b busy=%b exp 1/0/0/0", done_cnt, tmo_err, len_err, busy);
    end
  endtask

  task automatic test_four;
    for (int a = 0; a < 4; a++) begin
      pat[a] = 16'($urandom);
      sti[a] = {2'b00, 2'(a), 12'($urandom)};
      nval[a] = 8 * (a + 1);
      dly[a] = int'($urandom_range(1, 6));
    end
    model_run(3);
    kick(3);
    wait_done(1000);
    n_chk++;
    if (got_q.size() !== 4) begin n_fail++; $display("FAIL four_loads: got %0d exp 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL four_rec%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    n_chk++;
    if ({done_cnt, len_err, tmo_err} !== {32'd1, 2'b00}) begin
      n_fail++; $display("FAIL four_end: got done=%0d len=%b tmo=%b exp 1/0/0", done_cnt, len_err, tmo_err);
    end
  endtask

  task automatic test_len_err;
    fill_rand(2, 1'b0);
    sti[1][13:12] = 2'b01;
    nval[1] = 15;
    kick(2);
    for (int i = 0; i < 400 && !(load && mem_addr == 2); i++) @(negedge clk);
    n_chk++;
    if ({load, mem_addr, len_err} !== {1'b1, AW'(2), 1'b1}) begin
      n_fail++; $display("FAIL len_err_after_word1: got load=%b addr=%0d len_err=%b exp 1/2/1", load, mem_addr, len_err);
    end
    wait_done(400);
    n_chk++;
    if ({got_q.size(), done_cnt, len_err, tmo_err} !== {32'd3, 32'd1, 2'b10}) begin
      n_fail++; $display("FAIL len_err_end: got loads=%0d done=%0d len=%b tmo=%b exp 3/1/1/0", got_q.size(), done_cnt, len_err, tmo_err);
    end
  endtask

  task automatic test_timeout;
    fill_rand(2, 1'b0);
    nval[0] = 0;
    kick(2);
    for (int i = 0; i < 10 && !load; i++) @(negedge clk);
    n_chk++;
    if (load !== 1'b1) begin n_fail++; $display("FAIL tmo_load_seen: got %b exp 1", load); end
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (k == TMO - 1) begin
        n_chk++;
        if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b exp 0 at %0d cycles", tmo_err, k); end
      end
    end
    n_chk++;
    if ({tmo_err, done} !== 2'b11) begin n_fail++; $display("FAIL tmo_at_limit: got tmo=%b done=%b exp 1/1", tmo_err, done); end
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, tmo_err, got_q.size()} !== {2'b01, 32'd1}) begin
      n_fail++; $display("FAIL tmo_after: got busy=%b tmo=%b loads=%0d exp 0/1/1", busy, tmo_err, got_q.size());
    end
  endtask

  task automatic test_reset_midrun;
    fill_rand(3, 1'b0);
    kick(3);
    for (int i = 0; i < 800 && !(busy && mem_addr == 2 && so_valid); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({mem_addr, pi_data, pi_length, pi_fill, pi_msb, pi_low, load, mem_rd, pi_end, busy, done, tmo_err, len_err} !== '0) begin
      n_fail++; $display("FAIL midrun_reset_outputs: got addr=%h data=%h busy=%b, required all zero", mem_addr, pi_data, busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    n_chk++;
    if (done_cnt !== 0) begin n_fail++; $display("FAIL midrun_no_done: got %0d exp 0", done_cnt); end
    repeat (80) @(negedge clk);
    fill_rand(3, 1'b0);
    model_run(3);
    kick(3);
    wait_done(1000);
    n_chk++;
    if ({got_q.size(), done_cnt, len_err, tmo_err} !== {32'd4, 32'd1, 2'b00}) begin
      n_fail++; $display("FAIL midrun_rerun: got loads=%0d done=%0d len=%b tmo=%b exp 4/1/0/0", got_q.size(), done_cnt, len_err, tmo_err);
    end
  endtask

  task automatic test_start_busy;
    logic [AW-1:0] held;
    fill_rand(3, 1'b0);
    model_run(3);
    kick(3);
    for (int w = 0; w < 4; w += 2) begin
      for (int i = 0; i < 400 && !(load && mem_addr == AW'(w)); i++) @(negedge clk);
      held = mem_addr;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_chk++;
      if (mem_addr !== held || held !== AW'(w)) begin
        n_fail++; $display("FAIL busy_start_addr%0d: got %0d exp %0d", w, mem_addr, w);
      end
    end
    wait_done(1000);
    n_chk++;
    if ({got_q.size(), done_cnt} !== {32'd4, 32'd1}) begin
      n_fail++; $display("FAIL busy_start_loads: got loads=%0d done=%0d exp 4/1", got_q.size(), done_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_rec%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      automatic int last = int'($urandom_range(0, 5));
      fill_rand(last, 1'b1);
      model_run(last);
      kick(last);
      wait_done(2000);
      n_chk++;
      if (got_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_loads: got %0d exp %0d", r, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_chk++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_rec%0d: got %h exp %h", r, i, got_q[i], exp_q[i]); end
      end
      n_chk++;
      if ({done_cnt, tmo_err, len_err, busy, pi_end} !== {32'd1, exp_tmo, exp_len, 2'b00}) begin
        n_fail++;
        $display("FAIL rand%0d_flags: got done=%0d tmo=%b len=%b busy=%b end=%b exp 1/%b/%b/0/0", r, done_cnt, tmo_err, len_err, busy, pi_end, exp_tmo, exp_len);
      end
      repeat (int'($urandom_range(1, 4))) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 128; a++) begin
      pat[a] = '0; sti[a] = '0; nval[a] = 8; dly[a] = 1;
    end
    test_reset;
    test_single;
    test_four;
    test_len_err;
    test_timeout;
    test_reset_midrun;
    test_start_busy;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
